// File: rtl/store_buffer.sv
// +----------------------------------------------------------------------------+
// | Module   : store_buffer                                                    |
// | Purpose  : Posted-write FIFO between EX/MEM and data_memory; forwards      |
// |            loads from queued stores and drains in free port cycles.        |
// | Options  : STORE_BUF_COALESCE_EN - stores to a buffered address merge      |
// |            into the existing entry instead of allocating a new one.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          stall,
  input  logic          drain_req,
  output logic          empty,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  localparam int              c_PW      = $clog2(DEPTH);
  localparam logic [c_PW:0]   c_FULL    = (c_PW+1)'(DEPTH);
  localparam logic [c_PW:0]   c_CNT_ONE = (c_PW+1)'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);

  logic [AW-1:0]   r_addr [DEPTH];
  logic [DW-1:0]   r_data [DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_PW:0]   r_count;

  logic          w_full;
  logic          w_ld_match;
  logic [DW-1:0] w_ld_fwd;
  logic          w_hit;
  logic          w_drain;
  logic          w_coal;
  logic          w_enq;

  assign w_full = (r_count == c_FULL);
  assign empty  = (r_count == '0);

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    w_ld_match = 1'b0;
    w_ld_fwd   = '0;
    for (int i = 0; i < DEPTH; i++) begin : g_ld_search
      logic [c_PW-1:0] idx;
      idx = r_head + c_PW'(i);
      if (((c_PW+1)'(i) < r_count) && (r_addr[idx] == ld_addr)) begin
        w_ld_match = 1'b1;
        w_ld_fwd   = r_data[idx];
      end
    end
  end

  assign w_hit   = ld_valid && w_ld_match;
  // The port is free for a drain unless a missing load needs it; full and
  // drain_req override the load.
  assign w_drain = !rst && (r_count != '0) &&
                   (!ld_valid || w_hit || w_full || drain_req);

`ifdef STORE_BUF_COALESCE_EN
  logic            w_st_match;
  logic [c_PW-1:0] w_st_idx;

  always_comb begin
    w_st_match = 1'b0;
    w_st_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin : g_st_search
      logic [c_PW-1:0] idx;
      idx = r_head + c_PW'(i);
      if (((c_PW+1)'(i) < r_count) && (r_addr[idx] == st_addr)) begin
        w_st_match = 1'b1;
        w_st_idx   = idx;
      end
    end
  end

  // A head entry leaving this cycle cannot absorb the store.
  assign w_coal = st_valid && w_st_match && !(w_drain && (w_st_idx == r_head));
`else
  assign w_coal = 1'b0;
`endif

  assign w_enq = st_valid && !w_full && !w_coal;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    ld_data   = '0;
    if (w_drain) begin
      mem_write = 1'b1;
      mem_addr  = r_addr[r_head];
      mem_wdata = r_data[r_head];
    end else if (ld_valid && !w_hit) begin
      mem_read  = 1'b1;
      mem_addr  = ld_addr;
    end
    if (w_hit) begin
      ld_data = w_ld_fwd;
    end else if (ld_valid && !w_drain) begin
      ld_data = mem_rdata;
    end
  end

  assign stall = (st_valid && w_full && !w_coal) ||
                 (ld_valid && !w_hit && w_drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_drain) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_enq) begin
        r_addr[r_tail] <= st_addr;
        r_data[r_tail] <= st_data;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (w_coal) begin
        r_data[w_st_idx] <= st_data;
      end
`endif
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= c_FULL);
  a_port_excl   : assert property (@(posedge clk) disable iff (rst) !(mem_write && mem_read));

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_store_buffer                                                 |
// | Purpose  : Randomized and directed check of store_buffer against a         |
// |            queue-based reference model and a bench-owned data memory.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        stall;
  logic        drain_req;
  logic        empty;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  ent_t        q [$];
  int          n_vec;
  int          n_err;
  int          cyc;

  assign mem_rdata = dmem[mem_addr[7:0]];

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .stall(stall), .drain_req(drain_req), .empty(empty),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs, compare every output to the model, advance model.
  task automatic step(input bit r, input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input bit lv, input logic [31:0] la, input bit dq);
    ent_t de;
    ent_t ne;
    int   hidx;
    int   m;
    bit   full, hit, drn, coal;
    logic [31:0] e_addr, e_wdata, e_ld;
    @(negedge clk);
    rst = r; st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; drain_req = dq;
    #1;
    cyc++;
    full = (q.size() == DEPTH);
    hidx = -1;
    if (lv) foreach (q[i]) if (q[i].a == la) hidx = i;
    hit = (hidx >= 0);
    drn = !r && (q.size() > 0) && (!lv || hit || full || dq);
    m = -1;
    coal = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    foreach (q[i]) if (q[i].a == sa) m = i;
    coal = sv && (m >= 0) && !(m == 0 && drn);
`endif
    e_addr  = drn ? q[0].a : ((lv && !hit) ? la : 32'h0);
    e_wdata = drn ? q[0].d : 32'h0;
    e_ld    = hit ? q[hidx].d : ((lv && !drn) ? ref_mem[la[7:0]] : 32'h0);
    chk("empty",     {31'b0, empty},     {31'b0, q.size() == 0});
    chk("mem_write", {31'b0, mem_write}, {31'b0, drn});
    chk("mem_read",  {31'b0, mem_read},  {31'b0, !drn && lv && !hit});
    chk("mem_addr",  mem_addr,  e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("ld_data",   ld_data,   e_ld);
    chk("stall",     {31'b0, stall},
        {31'b0, (sv && full && !coal) || (lv && !hit && drn)});
    if (mem_write) dmem[mem_addr[7:0]] = mem_wdata;
    if (r) begin
      q.delete();
    end else begin
      if (drn) begin
        de = q[0];
        ref_mem[de.a[7:0]] = de.d;
      end
      if (coal) begin
        ne = q[m];
        ne.d = sd;
        q[m] = ne;
      end
      if (drn) void'(q.pop_front());
      if (sv && !full && !coal) begin
        ne.a = sa;
        ne.d = sd;
        q.push_back(ne);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; drain_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    dmem[50] = 32'h1234; ref_mem[50] = 32'h1234;

    // Reset and idle
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    idle();
    chk("lit_reset_empty", {31'b0, empty}, 32'd1);
    chk("lit_reset_stall", {31'b0, stall}, 32'd0);
    chk("lit_reset_mw",    {31'b0, mem_write}, 32'd0);
    chk("lit_reset_mr",    {31'b0, mem_read}, 32'd0);

    // Two stores drain in order
    step(1'b0, 1'b1, 5, 32'h11, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 9, 32'h22, 1'b0, 0, 1'b0);
    chk("lit_drain0_addr", mem_addr, 32'd5);
    chk("lit_drain0_data", mem_wdata, 32'h11);
    idle();
    chk("lit_drain1_addr", mem_addr, 32'd9);
    chk("lit_drain1_data", mem_wdata, 32'h22);
    idle();
    chk("lit_drained_empty", {31'b0, empty}, 32'd1);
    chk("lit_dmem5", dmem[5], 32'h11);
    chk("lit_dmem9", dmem[9], 32'h22);

    // Youngest-match forwarding
    step(1'b0, 1'b1, 7, 32'hAA, 1'b1, 100, 1'b0);
    step(1'b0, 1'b1, 7, 32'hBB, 1'b1, 100, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b1, 7, 1'b0);
    chk("lit_fwd_data", ld_data, 32'hBB);
    chk("lit_fwd_mr",   {31'b0, mem_read}, 32'd0);

    // Fill, then a fifth store stalls until a drain frees a slot
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 20 + i, 32'hA0 + i, 1'b1, 100, 1'b0);
    step(1'b0, 1'b1, 24, 32'hB4, 1'b1, 100, 1'b0);
    chk("lit_full_stall", {31'b0, stall}, 32'd1);
    chk("lit_full_mw",    {31'b0, mem_write}, 32'd1);
    step(1'b0, 1'b1, 24, 32'hB4, 1'b1, 100, 1'b0);
    chk("lit_enq_stall", {31'b0, stall}, 32'd0);
    chk("lit_enq_ld",    ld_data, 32'h1000_0064);

    // Full buffer with a missing load: one stall cycle, then served
    step(1'b0, 1'b0, 0, 0, 1'b1, 50, 1'b0);
    chk("lit_conf_stall", {31'b0, stall}, 32'd1);
    chk("lit_conf_mw",    {31'b0, mem_write}, 32'd1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 50, 1'b0);
    chk("lit_conf2_stall", {31'b0, stall}, 32'd0);
    chk("lit_conf2_ld",    ld_data, 32'h1234);

    // Reset discards queued stores
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 40 + i, 32'hC0 + i, 1'b1, 100, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    chk("lit_rst_mw", {31'b0, mem_write}, 32'd0);
    idle();
    chk("lit_rst_empty", {31'b0, empty}, 32'd1);
    for (int i = 0; i < 3; i++) chk("lit_rst_dmem", dmem[40 + i], 32'h1000_0028 + i);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      end else begin
        step(1'b0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 9) < 6, 32'($urandom_range(0, 31)),
             $urandom_range(0, 9) == 0);
      end
    end

    // Flush and compare whole memory
    for (int n = 0; n < DEPTH + 2; n++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
    chk("final_empty", {31'b0, empty}, 32'd1);
    for (int i = 0; i < 256; i++) chk("final_dmem", dmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the EX/MEM pipeline register and data_memory.
- Stores are queued in a FIFO and retire so a store costs no MEM-stage cycle. Entries drain to data_memory in cycles when no load needs the single memory port.
- Loads are checked against queued stores. A hit is forwarded from the buffer; a miss reads memory combinationally, the same cycle.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- AW, 32, address width; word address, matches ramAddress.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- st_valid  in  1  MEM-stage store request (memWrite from pipeline).
- st_addr  in  AW  store word address.
- st_data  in  DW  store data.
- ld_valid  in  1  MEM-stage load request (memRead from pipeline).
- ld_addr  in  AW  load word address.
- ld_data  out  DW  load result, combinational, same cycle.
- stall  out  1  pipeline must hold the MEM-stage instruction this cycle.
- drain_req  in  1  drain all entries; used before halt or program end.
- empty  out  1  buffer holds no entries.
- mem_addr  out  AW  to data_memory ramAddress.
- mem_wdata  out  DW  to data_memory writeData.
- mem_write  out  1  to data_memory memWrite.
- mem_read  out  1  to data_memory memRead.
- mem_rdata  in  DW  from data_memory readData.

Behaviour:
- State:
  - Circular array of DEPTH entries {addr, data}.
  - Head pointer, tail pointer, count register of width clog2(DEPTH)+1.
  - full = (count == DEPTH); empty = (count == 0).
- Reset: head = tail = count = 0, so empty = 1.
  - Combinational outputs with all inputs low: stall = 0, mem_write = 0, mem_read = 0, mem_addr = 0, mem_wdata = 0, ld_data = 0.
  - rst mid-operation discards all queued stores. No drain occurs in the reset cycle.
- Load hit:
  - hit = ld_valid and some valid entry addr == ld_addr.
  - ld_data = data of the youngest matching entry, searched from tail-1 back toward head.
- Load miss:
  - ld_valid and not hit: ld_data = mem_rdata, mem_read = 1, mem_addr = ld_addr.
  - Only occurs when the port is not claimed by a forced drain.
- Drain selection each cycle; drain fires when count > 0 and any of:
  - ld_valid = 0;
  - hit;
  - full;
  - drain_req.
- Drain action: mem_write = 1, mem_addr = head.addr, mem_wdata = head.data, mem_read = 0; head and count advance at the clock edge.
- Port conflict: full and a missing load in the same cycle.
  - The drain wins; stall = 1 and ld_data = 0.
  - Next cycle count = DEPTH-1, so the load is served. Stall lasts at most 1 cycle.
- drain_req with a missing load:
  - The drain wins and stall = 1 while count > 0.
  - Once empty, the load is served normally.
- Store enqueue: st_valid and not full writes {st_addr, st_data} at the tail; tail and count advance.
  - st_valid and full: stall = 1, nothing enqueued.
  - Enqueue and drain in the same cycle: count unchanged.
  - No bypass from st_valid to the memory port in the same cycle.
- stall = (st_valid and full) or (ld_valid and not hit and port taken by drain).
- st_valid and ld_valid together:
  - The load searches existing entries only.
  - The store enqueues if not full.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined: a store whose st_addr matches a valid entry overwrites that entry's data in place.
  - No allocation, count unchanged, no stall even when full.
  - If the match is the head entry and the head drains this cycle, the store allocates a new entry instead, under normal full rules.
  - At most one entry per address, so forwarding selects the single match.
- Undefined: every store allocates a new entry, duplicate addresses allowed, youngest-match forwarding applies.

Test Plan:
- Reset, then idle → empty = 1, stall = 0, mem_write = 0, mem_read = 0.
- Stores A=5/D=0x11, A=9/D=0x22 on back-to-back cycles with no loads → entries drain in order: mem_write with addr 5 then addr 9; data_memory holds 0x11 at 5 and 0x22 at 9; empty = 1 after 2 drain cycles.
- Hold drain off with back-to-back missing loads to addr 100, then issue 4 stores to DEPTH=4, then a 5th store → stall = 1 on the 5th; it enqueues the cycle after a drain.
- Queue A=7/D=0xAA then A=7/D=0xBB with the port held by loads, then load addr 7 → ld_data = 0xBB, mem_read = 0. With STORE_BUF_COALESCE_EN defined, count = 1 after the two stores.
- Buffer full, load of addr 50 (memory holds 0x1234, not buffered) → cycle 1: stall = 1, mem_write = 1; cycle 2: stall = 0, ld_data = 0x1234.
- 3 entries queued, assert rst for one cycle → empty = 1 next cycle, no mem_write ever issued for those entries.
